// File: rtl/fpga_timebase_pkg.sv
// Shared encodings and sizing for the timebase controller and its counter.
package fpga_timebase_pkg;

  localparam int PERIOD_W = 17;
  localparam logic [PERIOD_W-1:0] DEFAULT_PERIOD = 17'd124999;

  typedef enum logic [1:0] {
    OP_SET_PERIOD = 2'd0,
    OP_START      = 2'd1,
    OP_STOP       = 2'd2,
    OP_ABORT      = 2'd3
  } cfg_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/fpga_timebase_cnt.sv
// Loadable divide-by-(P+1) counter; strobes o_wrap on the cycle it sits at P.
module fpga_timebase_cnt
  import fpga_timebase_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  input  logic                i_enable,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_wrap
);

  logic [PERIOD_W-1:0] r_count;
  logic                w_wrap;

  assign w_wrap = i_enable && (r_count == i_period);
  assign o_wrap = w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear || w_wrap) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/fpga_timebase_ctrl.sv
// Timebase controller: command handshake, run/drain FSM, deferred period
// updates and the registered tick / divided clock / tick counter outputs.
module fpga_timebase_ctrl
  import fpga_timebase_pkg::*;
(
  input  logic                clk25mhz,
  input  logic                reset_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_op,
  input  logic [PERIOD_W-1:0] cfg_data,
  output logic                tick,
  output logic                clk_out,
  output logic                running,
  output logic [15:0]         tick_count
);

  state_e              r_state;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_pendData;
  logic                r_pendValid;
  logic                r_tick;
  logic                r_clkOut;
  logic [15:0]         r_tickCount;

  cfg_op_e             w_op;
  logic                w_accept;
  logic                w_wrap;
  logic                w_clear;
  logic                w_enable;

  assign w_op     = cfg_op_e'(cfg_op);
  assign w_accept = cfg_valid && !r_pendValid;
  assign w_enable = (r_state != ST_IDLE);
  assign w_clear  = w_accept && ((w_op == OP_ABORT) ||
                                 ((w_op == OP_START) && (r_state == ST_IDLE)));

  fpga_timebase_cnt u_cnt (
    .i_clk    (clk25mhz),
    .i_rst_n  (reset_n),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .i_period (r_period),
    .o_wrap   (w_wrap)
  );

  // Wrap handling first; an accepted command on the same edge overrides it.
  always_ff @(posedge clk25mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_period    <= DEFAULT_PERIOD;
      r_pendData  <= '0;
      r_pendValid <= 1'b0;
      r_tick      <= 1'b0;
      r_clkOut    <= 1'b0;
      r_tickCount <= '0;
    end else begin
      r_tick <= w_wrap;
      if (w_wrap) begin
        r_clkOut    <= ~r_clkOut;
        r_tickCount <= r_tickCount + 16'd1;
        if (r_pendValid) begin
          r_period    <= r_pendData;
          r_pendValid <= 1'b0;
        end
        if ((r_state == ST_DRAIN) && r_clkOut) begin
          r_state <= ST_IDLE;
        end
      end
      if (w_accept) begin
        unique case (w_op)
          OP_SET_PERIOD: begin
            if (r_state == ST_IDLE) begin
              r_period <= cfg_data;
            end else begin
              r_pendData  <= cfg_data;
              r_pendValid <= 1'b1;
            end
          end
          OP_START: begin
            if (r_state == ST_IDLE) begin
              r_state     <= ST_RUN;
              r_clkOut    <= 1'b0;
              r_tickCount <= '0;
            end else if (r_state == ST_DRAIN) begin
              r_state <= ST_RUN;
            end
          end
          OP_STOP: begin
            if (r_state == ST_RUN) begin
              r_state <= ST_DRAIN;
            end
          end
          OP_ABORT: begin
            r_state     <= ST_IDLE;
            r_clkOut    <= 1'b0;
            r_tickCount <= '0;
            r_pendValid <= 1'b0;
            r_tick      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_ready  = !r_pendValid;
  assign tick       = r_tick;
  assign clk_out    = r_clkOut;
  assign tick_count = r_tickCount;
  assign running    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fpga_timebase_ctrl.sv
// Directed bench for fpga_timebase_ctrl: hand-computed tick spacing, clk_out
// phase, handshake stalls, drain exit, abort and tick_count wrap.
module tb_fpga_timebase_ctrl;
  import fpga_timebase_pkg::*;

  logic        clk25mhz = 1'b0;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_op;
  logic [16:0] cfg_data;
  logic        tick;
  logic        clk_out;
  logic        running;
  logic [15:0] tick_count;

  int checks = 0;
  int errors = 0;

  fpga_timebase_ctrl dut (
    .clk25mhz   (clk25mhz),
    .reset_n    (reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_op     (cfg_op),
    .cfg_data   (cfg_data),
    .tick       (tick),
    .clk_out    (clk_out),
    .running    (running),
    .tick_count (tick_count)
  );

  always #5 clk25mhz = ~clk25mhz;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk25mhz);
    #1;
  endtask

  // Drive one command; returns one cycle after its acceptance edge.
  task automatic applyStimulus(input cfg_op_e op, input logic [16:0] data);
    int waited = 0;
    while (!cfg_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!cfg_ready) checkOutput("cmdReadyTimeout", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_op    = op;
    cfg_data  = data;
    step();
    cfg_valid = 1'b0;
  endtask

  // Counts edges until tick is seen high; a missing tick shows as a count mismatch.
  task automatic waitTick(input string tag, input int expected);
    int n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < expected + 20);
    checkOutput(tag, n, expected);
  endtask

  initial begin
    int ticks;
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_op    = 2'd0;
    cfg_data  = '0;
    step(); step(); step();
    checkOutput("rstTick", tick, 0);
    checkOutput("rstClkOut", clk_out, 0);
    checkOutput("rstRunning", running, 0);
    checkOutput("rstTickCount", tick_count, 0);
    checkOutput("rstReady", cfg_ready, 1);
    reset_n = 1'b1;
    step();

    $display("[TB] default period start");
    applyStimulus(OP_START, '0);
    checkOutput("defRunning", running, 1);
    ticks = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (tick) ticks++;
    end
    checkOutput("defNoEarlyTick", ticks, 0);
    applyStimulus(OP_ABORT, '0);
    checkOutput("defAbortRunning", running, 0);

    $display("[TB] P=3 run");
    applyStimulus(OP_SET_PERIOD, 17'd3);
    checkOutput("idleSetReady", cfg_ready, 1);
    applyStimulus(OP_START, '0);
    checkOutput("p3TickCountStart", tick_count, 0);
    waitTick("p3FirstTick", 4);
    checkOutput("p3ClkOut1", clk_out, 1);
    checkOutput("p3TickCount1", tick_count, 1);
    step();
    checkOutput("p3TickOneCycle", tick, 0);
    waitTick("p3Tick2", 3);
    for (int i = 3; i <= 10; i++) waitTick("p3TickN", 4);
    checkOutput("p3TickCount10", tick_count, 10);
    checkOutput("p3ClkOut10", clk_out, 0);

    $display("[TB] pending period update");
    step();
    cfg_valid = 1'b1;
    cfg_op    = OP_SET_PERIOD;
    cfg_data  = 17'd9;
    step();
    cfg_op    = OP_ABORT;
    checkOutput("pendReadyLow", cfg_ready, 0);
    step();
    checkOutput("pendReadyLow2", cfg_ready, 0);
    checkOutput("pendHeldRunning", running, 1);
    step();
    cfg_valid = 1'b0;
    checkOutput("pendOldPeriodTick", tick, 1);
    checkOutput("pendReadyBack", cfg_ready, 1);
    checkOutput("pendHeldRunning2", running, 1);
    checkOutput("pendTickCount", tick_count, 11);
    waitTick("p9Tick1", 10);
    waitTick("p9Tick2", 10);
    checkOutput("p9TickCount", tick_count, 13);

    $display("[TB] stop and drain");
    applyStimulus(OP_SET_PERIOD, 17'd3);
    waitTick("backToP3", 9);
    checkOutput("drainPreClk", clk_out, 0);
    applyStimulus(OP_STOP, '0);
    checkOutput("drainRunning", running, 1);
    waitTick("drainTick1", 3);
    checkOutput("drainClkHigh", clk_out, 1);
    checkOutput("drainStillRunning", running, 1);
    waitTick("drainTick2", 4);
    checkOutput("drainClkLow", clk_out, 0);
    checkOutput("drainIdle", running, 0);
    checkOutput("drainTickCount", tick_count, 16);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick) ticks++;
    end
    checkOutput("idleNoTicks", ticks, 0);

    $display("[TB] abort");
    applyStimulus(OP_START, '0);
    checkOutput("restartTickCount", tick_count, 0);
    waitTick("abortPreTick", 4);
    step();
    applyStimulus(OP_ABORT, '0);
    checkOutput("abortRunning", running, 0);
    checkOutput("abortClkOut", clk_out, 0);
    checkOutput("abortTickCount", tick_count, 0);
    checkOutput("abortTick", tick, 0);
    applyStimulus(OP_START, '0);
    step(); step(); step();
    applyStimulus(OP_ABORT, '0);
    checkOutput("abortOnWrapTick", tick, 0);
    checkOutput("abortOnWrapCount", tick_count, 0);

    $display("[TB] start from drain");
    applyStimulus(OP_START, '0);
    waitTick("sfdTick1", 4);
    applyStimulus(OP_STOP, '0);
    step();
    applyStimulus(OP_START, '0);
    waitTick("sfdNoCounterReset", 1);
    checkOutput("sfdRunning", running, 1);
    checkOutput("sfdClkOut", clk_out, 0);
    waitTick("sfdTick3", 4);
    checkOutput("sfdRunning2", running, 1);

    $display("[TB] P=0 run");
    applyStimulus(OP_ABORT, '0);
    applyStimulus(OP_SET_PERIOD, 17'd0);
    applyStimulus(OP_START, '0);
    waitTick("p0FirstTick", 1);
    checkOutput("p0ClkOut1", clk_out, 1);
    checkOutput("p0Count1", tick_count, 1);
    step();
    checkOutput("p0TickHeld", tick, 1);
    checkOutput("p0ClkOut2", clk_out, 0);
    checkOutput("p0Count2", tick_count, 2);
    for (int i = 0; i < 65533; i++) step();
    checkOutput("p0Count65535", tick_count, 65535);
    checkOutput("p0ClkOutOdd", clk_out, 1);
    step();
    checkOutput("p0CountWrap", tick_count, 0);
    checkOutput("p0TickAtWrap", tick, 1);
    checkOutput("p0ClkOutWrap", clk_out, 0);

    $display("[TB] async reset mid-period");
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncRstTick", tick, 0);
    checkOutput("asyncRstRunning", running, 0);
    checkOutput("asyncRstCount", tick_count, 0);
    checkOutput("asyncRstClkOut", clk_out, 0);
    step();
    reset_n = 1'b1;
    step();
    checkOutput("postRstTick", tick, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_timebase_ctrl.md
# fpga_timebase_ctrl

Programmable timebase controller for the FPGA subsystem. It sequences a divide-by-(P+1) counter running on the 25 MHz board clock, and produces a one-cycle tick pulse and a 50%-duty divided clock. Software-facing configuration logic drives it through a single command channel with a valid/ready handshake. By default it generates the 100 Hz benchmarking reference, but software can retune, start, stop gracefully and abort it at run time.

## Interface
- DEFAULT_PERIOD, 124999: reset value of period register P (wrap value); 17 bits.
- clk25mhz  in  1  sole clock, 25 MHz.
- reset_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  command valid.
- cfg_ready  out  1  command accepted on a cycle with cfg_valid && cfg_ready.
- cfg_op  in  2  command: 0 SET_PERIOD, 1 START, 2 STOP, 3 ABORT.
- cfg_data  in  17  new P for SET_PERIOD; ignored otherwise.
- tick  out  1  registered one-cycle pulse at each wrap.
- clk_out  out  1  registered divided clock, toggles at each wrap.
- running  out  1  high in RUN or DRAIN.
- tick_count  out  16  wrapping count of ticks since last START-from-IDLE or ABORT.

## Operation
- States:
  - IDLE: counter held at 0, no ticks.
  - RUN: counter counts 0..P, then wraps.
  - DRAIN: like RUN, stopping.
- Wrap event: state != IDLE and counter == P. On the wrap edge: counter←0, tick←1, clk_out←~clk_out, tick_count←tick_count+1 (mod 2^16).
- START:
  - From IDLE: counter←0, tick_count←0, clk_out←0, go to RUN.
  - In RUN: no effect.
  - In DRAIN: return to RUN; counter continues without reset.
- STOP:
  - From RUN: go to DRAIN.
  - In DRAIN: no effect.
  - In IDLE: no effect.
- DRAIN exit: at a wrap where clk_out toggles 1→0, go to IDLE. A wrap toggling 0→1 stays in DRAIN. IDLE is therefore always entered with clk_out = 0, within at most two periods.
- ABORT, any state:
  - Go to IDLE; counter←0, clk_out←0, tick_count←0.
  - Discard the pending period.
  - tick is 0 on the following cycle.
- SET_PERIOD:
  - In IDLE: P←cfg_data immediately.
  - In RUN or DRAIN: store in a one-deep pending register. It is applied at the next wrap edge, so the new P governs the following period.
- cfg_ready = !pending_valid. All commands, ABORT included, stall while an update is pending.
- P = 0 is legal: wrap on every running cycle, so tick stays high continuously.

## Timing
- Reset values: state IDLE, counter 0, P = DEFAULT_PERIOD, pending empty, tick 0, clk_out 0, running 0, tick_count 0, cfg_ready 1.
- Commands take effect on the acceptance edge; running reflects the new state the next cycle.
- First tick after START from IDLE: high in cycle P+1 after the acceptance edge, where the acceptance edge ends cycle 0. Ticks then repeat every P+1 cycles. clk_out period is 2(P+1).
- SET_PERIOD accepted on the same edge as a wrap: becomes pending and is applied at the next wrap, not the current one.
- STOP accepted on a wrap edge: the current wrap is processed as in RUN. DRAIN evaluation starts at the next wrap.
- Wrap while entering IDLE from DRAIN with an update pending: apply pending to P, and cfg_ready rises the next cycle.
- Asynchronous reset mid-period: all state returns to reset values immediately. No tick is issued.

## Structure
- Shared package fpga_timebase_pkg holds:
  - op encodings OP_SET_PERIOD/OP_START/OP_STOP/OP_ABORT;
  - state encoding ST_IDLE/ST_RUN/ST_DRAIN;
  - the period width constant (17).
- Optional sub-module fpga_timebase_cnt: the loadable counter with wrap compare, outputting a wrap strobe. The FSM, pending register and output registers stay in fpga_timebase_ctrl.

## Test plan
- Reset, then START with default P → first tick 125000 cycles after acceptance; clk_out period 250000 cycles; tick_count increments by 1 per tick.
- IDLE: SET_PERIOD 3, then START → ticks every 4 cycles; clk_out toggles every 4 cycles; tick_count after 10 ticks = 10.
- RUN at P=3, SET_PERIOD 9 accepted mid-period → cfg_ready low until the next wrap; that period stays 4 cycles, then periods are 10. A second command is held off while cfg_ready is low.
- RUN at P=3, STOP while clk_out=0 → one more tick (clk_out→1), DRAIN continues, next tick (clk_out→0) → IDLE, running low, no further ticks.
- RUN, ABORT mid-period → next cycle: IDLE, clk_out 0, tick_count 0, pending discarded. Then START from DRAIN → back to RUN with no counter reset.
- P=0 START → tick high every cycle, clk_out toggles every cycle; tick_count wraps 65535→0.
